// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin writeback arbiter for the single register-file
// write port, plus a per-register outstanding-write scoreboard that drives
// the hazard busy vector.
module rf_wb_arbiter #(
    parameter int CNT_W = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_a_valid,
    input  logic [4:0]  i_a_rd,
    input  logic [31:0] i_a_data,
    output logic        o_a_ready,
    input  logic        i_b_valid,
    input  logic [4:0]  i_b_rd,
    input  logic [31:0] i_b_data,
    output logic        o_b_ready,
    input  logic        i_iss_valid,
    input  logic [4:0]  i_iss_rd,
    output logic        o_iss_ready,
    output logic        o_rf_we,
    output logic [4:0]  o_rf_adrw,
    output logic [31:0] o_rf_wd,
    output logic [31:0] o_busy,
    output logic        o_wb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                        r_last_grant;  // 0 = A, 1 = B
    logic                        r_rf_we;
    logic [4:0]                  r_rf_adrw;
    logic [31:0]                 r_rf_wd;
    logic                        r_wb_err;
    logic [31:0][CNT_W-1:0]      w_cnt;         // w_cnt[0] is a constant zero

    logic        w_grant_a, w_grant_b;
    logic        w_hs_a, w_hs_b, w_hs;
    logic [4:0]  w_wb_rd;
    logic [31:0] w_wb_data;
    logic        w_iss_inc;
    logic        w_dec_err;

    // Round-robin grant: a lone requester always wins; on contention the
    // requester that did not win last time goes first.
    always_comb begin
        w_grant_a = i_a_valid && (!i_b_valid ||  r_last_grant);
        w_grant_b = i_b_valid && (!i_a_valid || !r_last_grant);
    end

    // Readies are held low during reset so nothing is consumed then.
    assign o_a_ready = i_rst_n && w_grant_a;
    assign o_b_ready = i_rst_n && w_grant_b;
    assign w_hs_a    = i_a_valid && o_a_ready;
    assign w_hs_b    = i_b_valid && o_b_ready;
    assign w_hs      = w_hs_a || w_hs_b;
    assign w_wb_rd   = w_hs_b ? i_b_rd   : i_a_rd;
    assign w_wb_data = w_hs_b ? i_b_data : i_a_data;

    // Issue stalls only on a saturated counter; uses registered state only.
    assign o_iss_ready = i_rst_n && !((i_iss_rd != 5'd0) && (w_cnt[i_iss_rd] == CNT_MAX));
    assign w_iss_inc   = i_iss_valid && o_iss_ready && (i_iss_rd != 5'd0);

    // A committed write for a register with nothing outstanding is an error.
    assign w_dec_err = r_rf_we && (w_cnt[r_rf_adrw] == '0);

    // Last-grant pointer advances only on a handshake.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)    r_last_grant <= 1'b1;
        else if (w_hs)   r_last_grant <= w_hs_b;
    end

    // Registered write port; x0 writes are consumed but never asserted to the file.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rf_we   <= 1'b0;
            r_rf_adrw <= 5'd0;
            r_rf_wd   <= 32'd0;
        end else if (w_hs) begin
            r_rf_we   <= (w_wb_rd != 5'd0);
            r_rf_adrw <= w_wb_rd;
            r_rf_wd   <= w_wb_data;
        end else begin
            r_rf_we   <= 1'b0;
        end
    end

    // Sticky writeback-underflow flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)       r_wb_err <= 1'b0;
        else if (w_dec_err) r_wb_err <= 1'b1;
    end

    assign w_cnt[0]  = '0;
    assign o_busy[0] = 1'b0;

    genvar r;
    generate
        for (r = 1; r < 32; r++) begin : g_cnt
            logic             r_q;
            logic [CNT_W-1:0] r_c;
            logic             w_inc, w_dec;
            assign w_inc = w_iss_inc && (i_iss_rd == r[4:0]);
            assign w_dec = r_rf_we && (r_rf_adrw == r[4:0]);
            // Outstanding-write count: inc on issue, dec on commit, net zero if both.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n)                        r_c <= '0;
                else if (w_inc && !w_dec)            r_c <= r_c + 1'b1;
                else if (w_dec && !w_inc && r_c != 0) r_c <= r_c - 1'b1;
            end
            assign r_q       = (r_c != '0);
            assign w_cnt[r]  = r_c;
            assign o_busy[r] = r_q;
        end
    endgenerate

    assign o_rf_we   = r_rf_we;
    assign o_rf_adrw = r_rf_adrw;
    assign o_rf_wd   = r_rf_wd;
    assign o_wb_err  = r_wb_err;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed bench with a write-port scoreboard queue.
module tb_rf_wb_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_a_valid, i_b_valid, i_iss_valid;
    logic [4:0]  i_a_rd, i_b_rd, i_iss_rd;
    logic [31:0] i_a_data, i_b_data;
    logic        o_a_ready, o_b_ready, o_iss_ready, o_rf_we, o_wb_err;
    logic [4:0]  o_rf_adrw;
    logic [31:0] o_rf_wd, o_busy;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         q[$];
    logic [4:0]  e_adrw;
    logic [31:0] e_wd;

    rf_wb_arbiter #(.CNT_W(2)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_a_valid(i_a_valid), .i_a_rd(i_a_rd), .i_a_data(i_a_data), .o_a_ready(o_a_ready),
        .i_b_valid(i_b_valid), .i_b_rd(i_b_rd), .i_b_data(i_b_data), .o_b_ready(o_b_ready),
        .i_iss_valid(i_iss_valid), .i_iss_rd(i_iss_rd), .o_iss_ready(o_iss_ready),
        .o_rf_we(o_rf_we), .o_rf_adrw(o_rf_adrw), .o_rf_wd(o_rf_wd),
        .o_busy(o_busy), .o_wb_err(o_wb_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 with inputs set: record what the port must show
    // next cycle, clock once, then compare against the oldest entry.
    task automatic step();
        wr_t e;
        #1;
        chk("one_ready", 32'(o_a_ready && o_b_ready), 32'd0);
        if (i_a_valid && o_a_ready) begin
            e.we = (i_a_rd != 0); e.a = i_a_rd; e.d = i_a_data;
        end else if (i_b_valid && o_b_ready) begin
            e.we = (i_b_rd != 0); e.a = i_b_rd; e.d = i_b_data;
        end else begin
            e.we = 1'b0; e.a = e_adrw; e.d = e_wd;
        end
        e_adrw = e.a; e_wd = e.d;
        q.push_back(e);
        @(posedge i_clk); #1;
        e = q.pop_front();
        chk("rf_we",   32'(o_rf_we), 32'(e.we));
        chk("rf_adrw", 32'(o_rf_adrw), 32'(e.a));
        chk("rf_wd",   o_rf_wd, e.d);
    endtask

    initial begin
        logic [4:0] ar [4];
        logic [4:0] br [4];
        logic [4:0] seq [4];
        logic [4:0] isr [5];
        int ai, bi;
        ar  = '{5'd1, 5'd2, 5'd3, 5'd4};
        br  = '{5'd9, 5'd10, 5'd11, 5'd12};
        seq = '{5'd1, 5'd9, 5'd2, 5'd10};
        isr = '{5'd5, 5'd1, 5'd2, 5'd9, 5'd10};
        i_rst_n = 1'b0; i_a_valid = 1'b1; i_b_valid = 1'b0; i_iss_valid = 1'b1;
        i_a_rd = 5'd3; i_b_rd = 0; i_iss_rd = 5'd4; i_a_data = 0; i_b_data = 0;
        e_adrw = 0; e_wd = 0;

        // Reset state
        #3;
        chk("rst_we", 32'(o_rf_we), 0);
        chk("rst_adrw", 32'(o_rf_adrw), 0);
        chk("rst_wd", o_rf_wd, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_err", 32'(o_wb_err), 0);
        chk("rst_a_ready", 32'(o_a_ready), 0);
        chk("rst_iss_ready", 32'(o_iss_ready), 0);
        i_a_valid = 1'b0; i_iss_valid = 1'b0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;

        // Issue destinations so the later writes are legitimate
        for (int k = 0; k < 5; k++) begin
            i_iss_valid = 1'b1; i_iss_rd = isr[k];
            #1 chk("iss_ready_init", 32'(o_iss_ready), 1);
            step();
        end
        i_iss_valid = 1'b0;
        chk("busy_after_issue", o_busy, 32'h0000_0626);

        // Single A write
        i_a_valid = 1'b1; i_a_rd = 5'd5; i_a_data = 32'hDEADBEEF;
        #1 chk("t1_a_ready", 32'(o_a_ready), 1);
        step();
        chk("t1_we", 32'(o_rf_we), 1);
        chk("t1_wd", o_rf_wd, 32'hDEADBEEF);
        i_a_valid = 1'b0;
        step();
        chk("t1_busy", o_busy, 32'h0000_0606);

        // x0 write from B
        i_b_valid = 1'b1; i_b_rd = 5'd0; i_b_data = 32'h1234;
        #1 chk("x0_b_ready", 32'(o_b_ready), 1);
        step();
        i_b_valid = 1'b0;
        chk("x0_we", 32'(o_rf_we), 0);
        step();
        chk("x0_busy", o_busy, 32'h0000_0606);
        chk("x0_err", 32'(o_wb_err), 0);

        // Continuous contention: A,B,A,B
        ai = 0; bi = 0;
        i_a_valid = 1'b1; i_b_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            i_a_rd = ar[ai]; i_a_data = 32'hA000_0000 | 32'(ar[ai]);
            i_b_rd = br[bi]; i_b_data = 32'hB000_0000 | 32'(br[bi]);
            #1;
            chk("rr_a_ready", 32'(o_a_ready), 32'(k % 2 == 0));
            chk("rr_b_ready", 32'(o_b_ready), 32'(k % 2 == 1));
            step();
            chk("rr_seq", 32'(o_rf_adrw), 32'(seq[k]));
            if (k % 2 == 0) ai++; else bi++;
        end
        i_a_valid = 1'b0; i_b_valid = 1'b0;
        step();
        chk("rr_busy", o_busy, 0);
        chk("rr_err", 32'(o_wb_err), 0);

        // Saturate cnt[7]
        i_iss_valid = 1'b1; i_iss_rd = 5'd7;
        for (int k = 0; k < 3; k++) begin
            #1 chk("sat_iss_ready", 32'(o_iss_ready), 1);
            step();
        end
        #1 chk("sat_stall", 32'(o_iss_ready), 0);
        step();
        i_a_valid = 1'b1; i_a_rd = 5'd7; i_a_data = 32'h77;
        #1 chk("sat_stall_hs", 32'(o_iss_ready), 0);
        step();
        i_a_valid = 1'b0;
        #1 chk("sat_stall_we", 32'(o_iss_ready), 0);
        step();
        i_iss_valid = 1'b0;
        #1 chk("sat_release", 32'(o_iss_ready), 1);
        i_a_valid = 1'b1;
        step();
        step();
        chk("sat_busy7_one_left", 32'(o_busy[7]), 1);
        i_a_valid = 1'b0;
        step();
        chk("sat_busy7_clear", 32'(o_busy[7]), 0);
        chk("sat_err", 32'(o_wb_err), 0);

        // Same-edge inc and dec on x3
        i_iss_valid = 1'b1; i_iss_rd = 5'd3;
        step();
        i_iss_valid = 1'b0;
        i_a_valid = 1'b1; i_a_rd = 5'd3; i_a_data = 32'h33;
        step();
        i_a_valid = 1'b0;
        i_iss_valid = 1'b1;
        #1 chk("same_iss_ready", 32'(o_iss_ready), 1);
        step();
        i_iss_valid = 1'b0;
        chk("same_busy3_a", 32'(o_busy[3]), 1);
        step();
        chk("same_busy3_b", 32'(o_busy[3]), 1);
        i_a_valid = 1'b1;
        step();
        i_a_valid = 1'b0;
        step();
        step();
        chk("same_busy3_done", 32'(o_busy[3]), 0);
        chk("same_err", 32'(o_wb_err), 0);

        // Underflow on x20
        i_a_valid = 1'b1; i_a_rd = 5'd20; i_a_data = 32'h20;
        step();
        i_a_valid = 1'b0;
        step();
        chk("uf_err_set", 32'(o_wb_err), 1);
        step();
        step();
        chk("uf_err_sticky", 32'(o_wb_err), 1);

        // Reset mid-operation
        i_iss_valid = 1'b1; i_iss_rd = 5'd8;
        step();
        step();
        i_iss_valid = 1'b0;
        i_a_valid = 1'b1; i_a_rd = 5'd8; i_a_data = 32'h88;
        step();
        i_a_valid = 1'b0;
        chk("mr_busy8", 32'(o_busy[8]), 1);
        i_rst_n = 1'b0;
        i_a_valid = 1'b1; i_iss_valid = 1'b1; i_iss_rd = 5'd1;
        #1;
        chk("mr_we", 32'(o_rf_we), 0);
        chk("mr_adrw", 32'(o_rf_adrw), 0);
        chk("mr_wd", o_rf_wd, 0);
        chk("mr_busy", o_busy, 0);
        chk("mr_err", 32'(o_wb_err), 0);
        chk("mr_a_ready", 32'(o_a_ready), 0);
        chk("mr_iss_ready", 32'(o_iss_ready), 0);
        i_a_valid = 1'b0; i_iss_valid = 1'b0;
        e_adrw = 0; e_wd = 0;
        @(posedge i_clk); @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        i_a_valid = 1'b1; i_a_rd = 5'd4; i_a_data = 32'h44;
        i_b_valid = 1'b1; i_b_rd = 5'd11; i_b_data = 32'hBB;
        #1;
        chk("post_rst_a_wins", 32'(o_a_ready), 1);
        chk("post_rst_b_waits", 32'(o_b_ready), 0);
        step();
        chk("post_rst_adrw", 32'(o_rf_adrw), 4);
        i_a_valid = 1'b0; i_b_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Writeback controller for the 32x32 integer register file, which has a single write port. It arbitrates two writeback requesters, the ALU/execute path (A) and the load/store unit (B), onto that port using round-robin order, and registers the winning write. It also keeps a per-register outstanding-write scoreboard, which issue logic uses for RAW/WAW hazard stalls. It sits between the execute/memory stages and the register file write port (adrw, wd, we).

## Interface
- CNT_W, 2: width of each per-register outstanding-write counter; max count 2^CNT_W-1
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- a_valid  in  1  requester A has a writeback
- a_rd  in  5  A destination register
- a_data  in  32  A write data
- a_ready  out  1  A handshake completes this cycle (a_valid && a_ready)
- b_valid, b_rd, b_data, b_ready  same as A, for requester B (LSU)
- iss_valid  in  1  an instruction with a destination is being issued
- iss_rd  in  5  its destination register
- iss_ready  out  1  issue accepted (iss_valid && iss_ready)
- rf_we  out  1  to register file we
- rf_adrw  out  5  to register file adrw
- rf_wd  out  32  to register file wd
- busy  out  32  busy[r]=1 while register r has outstanding writes; busy[0] is always 0
- wb_err  out  1  sticky: a writeback arrived for a register whose count was 0

## Operation
- Arbitration is combinational from valids and last_grant (1 bit, 0=A, 1=B).
  - Only A valid -> grant A. Only B valid -> grant B.
  - Both valid -> grant the requester other than last_grant.
  - At most one of a_ready/b_ready is high; ready never depends on the requester's own data.
- last_grant updates to the granted requester on every handshake. It holds when there is no handshake.
- Write register: on handshake, capture rd and data into rf_adrw/rf_wd.
  - rf_we is set to 1 if rd!=0, else 0. An x0 write is consumed but never written and never touches counters.
  - No handshake -> rf_we=0; rf_adrw/rf_wd hold.
- Scoreboard: cnt[1..31], CNT_W bits each; busy[r] = (cnt[r]!=0).
  - Issue inc: on an issue handshake with iss_rd!=0, cnt[iss_rd] += 1.
  - Write dec: on a posedge with rf_we=1, cnt[rf_adrw] -= 1.
  - Same register, inc and dec on the same edge -> count unchanged.
  - Dec with count 0 -> count stays 0 and wb_err is set to 1. wb_err clears only on reset.
- iss_ready = !(iss_rd!=0 && cnt[iss_rd]==max). iss_rd=0 is always ready.
  - At max, an issue stalls until a dec on the same edge is visible, i.e. the next cycle after the dec.
  - iss_ready depends only on registered state, never on same-cycle writebacks.

## Timing
- Reset (async assert; removal is synchronous to clk by the surrounding reset logic):
  - rf_we=0, rf_adrw=0, rf_wd=0
  - last_grant=1, so A wins the first contention
  - all cnt=0, busy=0, wb_err=0
- Writeback latency:
  - Handshake in cycle N -> rf_we/rf_adrw/rf_wd valid during cycle N+1 -> register file written at the edge ending N+1.
  - busy reflects the dec from cycle N+2, the same cycle the register file holds the new value. No forwarding is required from this block.
- Issue latency: handshake in cycle N -> busy[iss_rd] high from cycle N+1.
- Throughput: one write per cycle. Under continuous dual requests, grants strictly alternate A,B,A,B.
- Reset mid-operation:
  - The pending registered write is dropped (rf_we=0 immediately).
  - The scoreboard is cleared.
  - Requesters must re-present after reset.
- a_ready/b_ready/iss_ready are 0 while rst_n=0.

## Test plan
- Reset, then single A write (a_rd=5, a_data=0xDEADBEEF) in cycle 1 -> a_ready=1 in cycle 1; rf_we=1, rf_adrw=5, rf_wd=0xDEADBEEF in cycle 2; rf_we=0 in cycle 3.
- A and B both valid for 4 cycles (rd=1..4 vs 9..12) -> grants A,B,A,B; rf_adrw sequence 1,9,2,10. The losing requester holds its data and is served next.
- Write to x0 from B with data 0x1234 -> b_ready=1, rf_we=0 next cycle, busy unchanged, wb_err=0.
- Issue rd=7 three times (CNT_W=2), then with count=3 issue rd=7 again -> iss_ready=0. A write to 7 completes -> iss_ready=1 the cycle after the write edge. busy[7] drops only after three writes.
- Issue rd=3 and commit a write to 3 on the same edge with cnt[3]=1 -> cnt[3] stays 1 and busy[3] stays 1. A writeback to rd=20 with cnt[20]=0 -> wb_err=1, sticky until rst_n.
- Assert rst_n=0 while rf_we=1 and cnt[8]=2 -> rf_we, rf_adrw, busy and wb_err all 0 immediately (asynchronous). After release, A wins the first contention.
